// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding and default widths for the systolic array feeder.
package systolic_pkg;

  localparam int unsigned ARRAY_N_DEF = 4;
  localparam int unsigned BW_ACT_DEF  = 8;
  localparam int unsigned BW_WET_DEF  = 8;
  localparam int unsigned BW_ACCU_DEF = 32;
  localparam int unsigned BW_CNT_DEF  = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/systolic_array_feeder_if.sv
// systolic_array_feeder_if: weight-row and activation-vector ready/valid streams.
// master = upstream buffers, slave = feeder.
interface systolic_array_feeder_if
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned BW_ACT  = BW_ACT_DEF,
  parameter int unsigned BW_WET  = BW_WET_DEF
);

  logic                        wet_valid;
  logic                        wet_ready;
  logic [ARRAY_N*BW_WET-1:0]   wet_data;
  logic                        act_valid;
  logic                        act_ready;
  logic [ARRAY_N*BW_ACT-1:0]   act_data;

  modport master (
    output wet_valid, wet_data, act_valid, act_data,
    input  wet_ready, act_ready
  );

  modport slave (
    input  wet_valid, wet_data, act_valid, act_data,
    output wet_ready, act_ready
  );

endinterface

// File: rtl/systolic_skew_line.sv
// systolic_skew_line: DEPTH-stage delay of {enable, data}; DEPTH = 0 is a pass-through.
module systolic_skew_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_en,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_pass
    assign out_en   = in_en;
    assign out_data = in_data;
  end else begin : g_dly
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH:0] q;
      if (i == 0) begin : g_first
        // first stage captures the lane input
        always_ff @(posedge clk) begin
          if (reset) q <= '0;
          else       q <= {in_en, in_data};
        end
      end else begin : g_next
        // later stages shift the previous stage
        always_ff @(posedge clk) begin
          if (reset) q <= '0;
          else       q <= g_stage[i-1].q;
        end
      end
    end
    assign out_en   = g_stage[DEPTH-1].q[WIDTH];
    assign out_data = g_stage[DEPTH-1].q[WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_array_feeder.sv
// systolic_array_feeder: clears the PE array, shifts in a weight matrix one row per
// transfer, then streams diagonally skewed activation vectors and flushes the skew.
// Optional feature macro: SYSTOLIC_FEEDER_BIAS_EN (adds bias_data, injected on
// pe_above_out alongside each row-0 activation).
module systolic_array_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned BW_ACT  = BW_ACT_DEF,
  parameter int unsigned BW_WET  = BW_WET_DEF,
  parameter int unsigned BW_ACCU = BW_ACCU_DEF,
  parameter int unsigned BW_CNT  = BW_CNT_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_start,
  input  logic [BW_CNT-1:0]           cfg_k,
`ifdef SYSTOLIC_FEEDER_BIAS_EN
  input  logic [ARRAY_N*BW_ACCU-1:0]  bias_data,
`endif
  systolic_array_feeder_if.slave      up,
  output logic                        pe_clear_weight,
  output logic                        pe_weight_sel,
  output logic [ARRAY_N-1:0]          pe_mac_enable,
  output logic [ARRAY_N*BW_ACT-1:0]   pe_act_out,
  output logic [ARRAY_N*BW_ACCU-1:0]  pe_above_out,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned WCNT_W     = $clog2(ARRAY_N) + 1;
  localparam int unsigned WCNT_LAST  = ARRAY_N - 1;
  localparam int unsigned DRAIN_LAST = (ARRAY_N > 1) ? ARRAY_N - 2 : 0;

  feeder_state_e               state_q, state_d;
  logic [WCNT_W-1:0]           wcnt_q, wcnt_d;
  logic [WCNT_W-1:0]           dcnt_q, dcnt_d;
  logic [BW_CNT-1:0]           acnt_q, acnt_d;
  logic [BW_CNT-1:0]           k_q, k_d;
  logic                        wet_ready_q, wet_ready_d;
  logic                        act_ready_q, act_ready_d;
  logic [ARRAY_N-1:0]          lane_en_q, lane_en_d;
  logic [ARRAY_N*BW_ACT-1:0]   lane_data_q, lane_data_d;
  logic                        clear_d, sel_d, busy_d, done_d;
  logic [ARRAY_N*BW_ACCU-1:0]  above_d;
  logic [ARRAY_N*BW_ACCU-1:0]  wet_sext;
  logic                        wet_hs, act_hs;
`ifdef SYSTOLIC_FEEDER_BIAS_EN
  logic [ARRAY_N*BW_ACCU-1:0]  bias_q, bias_d;
`endif

  assign up.wet_ready = wet_ready_q;
  assign up.act_ready = act_ready_q;
  assign wet_hs       = up.wet_valid & wet_ready_q;
  assign act_hs       = up.act_valid & act_ready_q;

  // sign-extend each weight column to the partial-sum width
  for (genvar c = 0; c < ARRAY_N; c++) begin : g_sext
    assign wet_sext[c*BW_ACCU +: BW_ACCU] =
      BW_ACCU'($signed(up.wet_data[c*BW_WET +: BW_WET]));
  end

  // next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    dcnt_d      = dcnt_q;
    acnt_d      = acnt_q;
    k_d         = k_q;
    clear_d     = 1'b0;
    sel_d       = 1'b0;
    done_d      = 1'b0;
    above_d     = '0;
    lane_en_d   = '0;
    lane_data_d = '0;
`ifdef SYSTOLIC_FEEDER_BIAS_EN
    bias_d      = bias_q;
`endif

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          k_d     = cfg_k;
          wcnt_d  = '0;
          dcnt_d  = '0;
          acnt_d  = '0;
          state_d = CLEAR;
`ifdef SYSTOLIC_FEEDER_BIAS_EN
          bias_d  = bias_data;
`endif
        end
      end
      CLEAR: begin
        clear_d = 1'b1;
        state_d = LOAD_W;
      end
      LOAD_W: begin
        if (wet_hs) begin
          sel_d   = 1'b1;
          above_d = wet_sext;
          wcnt_d  = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(WCNT_LAST)) begin
            state_d = (k_q == '0) ? DONE : STREAM;
          end
        end
      end
      STREAM: begin
        if (act_hs) begin
          lane_en_d   = '1;
          lane_data_d = up.act_data;
`ifdef SYSTOLIC_FEEDER_BIAS_EN
          above_d     = bias_q;
`endif
          acnt_d      = acnt_q + BW_CNT'(1);
          if (acnt_q == k_q - BW_CNT'(1)) begin
            dcnt_d  = '0;
            state_d = (ARRAY_N > 1) ? DRAIN : DONE;
          end
        end
      end
      DRAIN: begin
        // last row presents the final element as DRAIN ends; DONE follows directly
        dcnt_d = dcnt_q + WCNT_W'(1);
        if (dcnt_q == WCNT_W'(DRAIN_LAST)) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_q != IDLE);
    wet_ready_d = (state_d == LOAD_W);
    act_ready_d = (state_d == STREAM);
  end

  // state, counters and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      wcnt_q          <= '0;
      dcnt_q          <= '0;
      acnt_q          <= '0;
      k_q             <= '0;
      wet_ready_q     <= 1'b0;
      act_ready_q     <= 1'b0;
      lane_en_q       <= '0;
      lane_data_q     <= '0;
      pe_clear_weight <= 1'b0;
      pe_weight_sel   <= 1'b0;
      pe_above_out    <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef SYSTOLIC_FEEDER_BIAS_EN
      bias_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      wcnt_q          <= wcnt_d;
      dcnt_q          <= dcnt_d;
      acnt_q          <= acnt_d;
      k_q             <= k_d;
      wet_ready_q     <= wet_ready_d;
      act_ready_q     <= act_ready_d;
      lane_en_q       <= lane_en_d;
      lane_data_q     <= lane_data_d;
      pe_clear_weight <= clear_d;
      pe_weight_sel   <= sel_d;
      pe_above_out    <= above_d;
      busy            <= busy_d;
      done            <= done_d;
`ifdef SYSTOLIC_FEEDER_BIAS_EN
      bias_q          <= bias_d;
`endif
    end
  end

  // row r adds r stages of skew behind the common lane register
  for (genvar r = 0; r < ARRAY_N; r++) begin : g_row
    systolic_skew_line #(
      .DEPTH (r),
      .WIDTH (BW_ACT)
    ) u_skew (
      .clk      (clk),
      .reset    (reset),
      .in_en    (lane_en_q[r]),
      .in_data  (lane_data_q[r*BW_ACT +: BW_ACT]),
      .out_en   (pe_mac_enable[r]),
      .out_data (pe_act_out[r*BW_ACT +: BW_ACT])
    );
  end

endmodule

// File: tb/tb_systolic_array_feeder.sv
// tb_systolic_array_feeder: randomized jobs checked cycle by cycle against an
// event-timeline model built from handshake times.
module tb_systolic_array_feeder;

  localparam int unsigned N    = 4;
  localparam int unsigned BA   = 8;
  localparam int unsigned BWT  = 8;
  localparam int unsigned BACC = 32;
  localparam int unsigned BC   = 16;
  localparam int unsigned CW   = N*BACC;
  localparam int          MAXC = 160;

  logic clk = 1'b0;
  logic reset;
  logic cfg_start;
  logic [BC-1:0] cfg_k;
  logic [N*BACC-1:0] bias_data;
  logic pe_clear_weight, pe_weight_sel, busy, done;
  logic [N-1:0] pe_mac_enable;
  logic [N*BA-1:0] pe_act_out;
  logic [N*BACC-1:0] pe_above_out;

  int n_chk  = 0;
  int n_fail = 0;

  logic              e_sel   [MAXC];
  logic [N*BACC-1:0] e_above [MAXC];
  logic [N-1:0]      e_en    [MAXC];
  logic [N*BA-1:0]   e_act   [MAXC];

  systolic_array_feeder_if #(.ARRAY_N(N), .BW_ACT(BA), .BW_WET(BWT)) up_if ();

  systolic_array_feeder #(
    .ARRAY_N(N), .BW_ACT(BA), .BW_WET(BWT), .BW_ACCU(BACC), .BW_CNT(BC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_start       (cfg_start),
    .cfg_k           (cfg_k),
`ifdef SYSTOLIC_FEEDER_BIAS_EN
    .bias_data       (bias_data),
`endif
    .up              (up_if),
    .pe_clear_weight (pe_clear_weight),
    .pe_weight_sel   (pe_weight_sel),
    .pe_mac_enable   (pe_mac_enable),
    .pe_act_out      (pe_act_out),
    .pe_above_out    (pe_above_out),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, ".clear"},   CW'(pe_clear_weight), '0);
    check({pfx, ".sel"},     CW'(pe_weight_sel), '0);
    check({pfx, ".en"},      CW'(pe_mac_enable), '0);
    check({pfx, ".act"},     CW'(pe_act_out), '0);
    check({pfx, ".above"},   CW'(pe_above_out), '0);
    check({pfx, ".busy"},    CW'(busy), '0);
    check({pfx, ".done"},    CW'(done), '0);
    check({pfx, ".wready"},  CW'(up_if.wet_ready), '0);
    check({pfx, ".aready"},  CW'(up_if.act_ready), '0);
  endtask

  // mode 0: random traffic; mode 1: directed patterns. abort_off > 0 resets mid-stream.
  task automatic run_job(input int k, input int mode, input int abort_off);
    int wcnt, acnt, lw, d, wstall, astall, idx;
    logic wv, av, wr, ar, whs, ahs, aborted, finished;
    logic [N*BWT-1:0] wd;
    logic [N*BA-1:0]  ad;
    logic [N*BACC-1:0] bias;
    for (int i = 0; i < MAXC; i++) begin
      e_sel[i] = 1'b0; e_above[i] = '0; e_en[i] = '0; e_act[i] = '0;
    end
    wcnt = 0; acnt = 0; lw = -1; d = -1; wstall = 0; astall = 0;
    wv = 1'b0; av = 1'b0; wd = '0; ad = '0; aborted = 1'b0; finished = 1'b0;
    if (mode == 1) begin
      bias = {32'd7, 32'd0, 32'hFFFF_FFFF, 32'd10};
    end else begin
      bias = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int c = 0; c < MAXC; c++) begin
      @(negedge clk);
      if (aborted) begin
        check_quiet("abort");
        reset = 1'b0;
        finished = 1'b1;
        break;
      end
      wr = (c >= 2) && (wcnt < N);
      ar = (lw >= 0) && (c > lw) && (acnt < k);
      check("wet_ready", CW'(up_if.wet_ready), CW'(wr));
      check("act_ready", CW'(up_if.act_ready), CW'(ar));
      check("busy",      CW'(busy), CW'((c >= 2) && (d < 0 || c <= d)));
      check("done",      CW'(done), CW'(c == d));
      check("clear",     CW'(pe_clear_weight), CW'(c == 2));
      check("weight_sel", CW'(pe_weight_sel), CW'(e_sel[c]));
      check("above",     CW'(pe_above_out), CW'(e_above[c]));
      check("mac_en",    CW'(pe_mac_enable), CW'(e_en[c]));
      check("act_out",   CW'(pe_act_out), CW'(e_act[c]));
      if (d >= 0 && c == d + 1) begin
        finished = 1'b1;
        break;
      end
      // drive this cycle's inputs
      cfg_start = (c == 0) || ((d < 0 || c < d) && $urandom_range(0, 9) == 0);
      cfg_k     = (c == 0) ? BC'(k) : BC'($urandom);
      bias_data = (c == 0) ? bias : {$urandom, $urandom, $urandom, $urandom};
      if (!wv && wcnt < N && c >= 1) begin
        if (mode == 1) wv = (c >= 2) && (c % 2 == 0);
        else           wv = (wstall >= 3) || ($urandom_range(0, 1) == 1);
        wstall = wv ? 0 : wstall + 1;
        if (wv) begin
          for (int col = 0; col < N; col++)
            wd[col*BWT +: BWT] = (mode == 1) ? 8'hFD : 8'($urandom);
        end
      end
      if (!av && acnt < k && c >= 1) begin
        if (mode == 1) av = !(k > 2 && lw >= 0 && (c == lw + 3 || c == lw + 4));
        else           av = (astall >= 3) || ($urandom_range(0, 1) == 1);
        astall = av ? 0 : astall + 1;
        if (av) begin
          for (int r = 0; r < N; r++)
            ad[r*BA +: BA] = (mode == 1) ? 8'(acnt*N + r + 1) : 8'($urandom);
        end
      end
      up_if.wet_valid = wv; up_if.wet_data = wd;
      up_if.act_valid = av; up_if.act_data = ad;
      if (abort_off > 0 && lw >= 0 && c == lw + abort_off) begin
        reset = 1'b1;
        aborted = 1'b1;
        continue;
      end
      // model the transfers this cycle implies
      whs = wv && wr;
      ahs = av && ar;
      if (whs) begin
        e_sel[c+1] = 1'b1;
        for (int col = 0; col < N; col++)
          e_above[c+1][col*BACC +: BACC] = 32'(int'($signed(wd[col*BWT +: BWT])));
        wcnt++;
        wv = 1'b0;
        if (wcnt == N) begin
          lw = c;
          if (k == 0) d = c + 2;
        end
      end
      if (ahs) begin
        for (int r = 0; r < N; r++) begin
          idx = c + 1 + r;
          if (idx < MAXC) begin
            e_en[idx][r] = 1'b1;
            e_act[idx][r*BA +: BA] = ad[r*BA +: BA];
          end
        end
`ifdef SYSTOLIC_FEEDER_BIAS_EN
        e_above[c+1] = bias;
`endif
        acnt++;
        av = 1'b0;
        if (acnt == k) d = c + N + 1;
      end
    end
    check("job_end", CW'(finished), CW'(1));
    cfg_start = 1'b0;
    up_if.wet_valid = 1'b0;
    up_if.act_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0;
    cfg_k = '0;
    bias_data = '0;
    up_if.wet_valid = 1'b0; up_if.wet_data = '0;
    up_if.act_valid = 1'b0; up_if.act_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    run_job(2, 1, 0);
    run_job(5, 1, 0);
    run_job(0, 0, 0);
    run_job(8, 0, 3);
    run_job(3, 1, 0);
    for (int j = 0; j < 8; j++) run_job($urandom_range(0, 12), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_feeder.md
Name: systolic_array_feeder

Overview:
- Drives the top and left edges of an ARRAY_N x ARRAY_N weight-stationary systolic array of PEs.
- Clears the PEs, then shifts a weight matrix down the columns one row per transfer.
- Then streams activation vectors into the rows with diagonal skew, and flushes the skew.
- Ready/valid toward the upstream buffers; raw PE control toward the array.

Parameters:
ARRAY_N, 4, rows = columns of the array
BW_ACT, 8, activation width (signed)
BW_WET, 8, weight width (signed)
BW_ACCU, 32, partial-sum width (signed)
BW_CNT, 16, width of the activation-vector count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_k  in  BW_CNT  number of activation vectors; sampled with cfg_start
wet_valid  in  1  weight row valid
wet_ready  out  1  weight row accepted
wet_data  in  ARRAY_N*BW_WET  one weight row, column c at [c*BW_WET +: BW_WET]
act_valid  in  1  activation vector valid
act_ready  out  1  activation vector accepted
act_data  in  ARRAY_N*BW_ACT  one vector, row r at [r*BW_ACT +: BW_ACT]
pe_clear_weight  out  1  clears all PE weight registers
pe_weight_sel  out  1  1 = weight shift, 0 = MAC
pe_mac_enable  out  ARRAY_N  per-row MAC enable, skewed
pe_act_out  out  ARRAY_N*BW_ACT  per-row activation, skewed
pe_above_out  out  ARRAY_N*BW_ACCU  per-column top input
busy  out  1  high outside IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including the skew registers and counters. Reset mid-operation aborts immediately; no done pulse.
- All pe_* outputs, busy and done are registered.
- FSM: IDLE -> CLEAR -> LOAD_W -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: wet_ready = act_ready = 0. On cfg_start, latch cfg_k and go to CLEAR. cfg_start in any other state is ignored.
- CLEAR: one cycle. pe_clear_weight = 1 on the next cycle. Then LOAD_W.
- LOAD_W:
  - wet_ready = 1.
  - On each wet handshake: next cycle pe_weight_sel = 1 and pe_above_out[c] = sign-extended wet_data[c].
  - Cycles with no handshake drive pe_weight_sel = 0 and pe_mac_enable = 0, so the weights hold.
  - Upstream sends the bottom row first.
  - After ARRAY_N handshakes: go to STREAM, or go to DONE if the latched k == 0.
- STREAM:
  - act_ready = 1 while accepted < k; the state exits after the k-th handshake.
  - Lane r delays act_data[r] by r stages on top of the common output register. A vector accepted at cycle t appears on row r at cycle t+1+r with pe_mac_enable[r] = 1.
  - A cycle with no handshake injects a bubble: activation 0, enable 0, still skewed.
  - pe_weight_sel = 0 and pe_above_out = 0 (see the optional feature).
- DRAIN: act_ready = 0. Lasts ARRAY_N cycles after the last handshake so row ARRAY_N-1 presents the last element. Bubbles shift in.
- DONE: one cycle, done = 1, busy = 1. Then IDLE with busy = 0.
- Handshake: transfer iff valid && ready. Data is held by upstream until accepted. ready never depends combinationally on valid.
- Counters saturate-free: the LOAD_W count is log2(ARRAY_N)+1 bits; the STREAM count is BW_CNT bits and compares against the latched k.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_BIAS_EN.
- Defined:
  - Adds input bias_data (ARRAY_N*BW_ACCU), sampled with cfg_start.
  - In STREAM/DRAIN, pe_above_out[c] = latched bias[c] on each cycle where that column's top PE receives a valid activation (row 0 enable = 1); otherwise 0.
- Undefined: no port; pe_above_out = 0 outside LOAD_W.

Decomposition:
- Package systolic_pkg: feeder_state_e enum (IDLE, CLEAR, LOAD_W, STREAM, DRAIN, DONE); default width localparams.
- Sub-module systolic_skew_line: parameter DEPTH and data width, carrying {enable, data}. Instantiate one per row with DEPTH = r; DEPTH = 0 is a pass-through.

Test Plan:
1. ARRAY_N = 4, start with k = 2:
   - Clear pulse on the cycle after start.
   - 4 weight rows accepted; pe_weight_sel high exactly 4 cycles.
   - Vectors {1,2,3,4} then {5,6,7,8}: row 3 shows 4 at t0+4 and 8 at t0+5.
   - done on the cycle after the last row-3 element; busy drops the next cycle.
2. wet_valid toggling 1,0,1,0: pe_weight_sel = 1 only after the handshake cycles; pe_above_out carries -3 (0xFD) sign-extended to 0xFFFFFFFD.
3. act_valid low for 2 cycles mid-stream: a 2-cycle bubble with enable 0 appears on each row, delayed r cycles per row; no data is lost.
4. k = 0: CLEAR and LOAD_W complete, then DONE directly; act_ready never asserted.
5. reset asserted during STREAM: next cycle all outputs 0, state IDLE, no done; a new start then runs normally.
6. SYSTOLIC_FEEDER_BIAS_EN with bias {10,-1,0,7}: pe_above_out carries bias while the row-0 enable is high, 0 on bubbles; macro off -> always 0.
